// File: rtl/epc_bridge_if.sv
// ----------------------------------------------------------------------------
// epc_bridge_if
// Bundles the EPC master side and the peripheral channel side of epc_bridge.
//   slave  : view taken by the bridge (EPC inputs, peripheral outputs)
//   master : view taken by the environment driving the bridge
// Signals:
//   epc_ncs/epc_nrd/epc_nwr  EPC chip select and strobes (active low, async)
//   epc_addr, epc_wdata      EPC address / write data
//   epc_rdata, epc_rdy       registered read data, access complete
//   p_ncs, p_rs, p_nrd,      per-channel chip selects (one-cold), register
//   p_nwr, p_wdata           select, peripheral strobes, latched write data
//   p_rdata, p_rdy           packed per-channel read data and ready
//   err_clr, timeout_err,    sticky error flag clear and flags
//   decode_err
// ----------------------------------------------------------------------------
interface epc_bridge_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    logic                       epc_ncs;
    logic [ADDR_W-1:0]          epc_addr;
    logic                       epc_nrd;
    logic                       epc_nwr;
    logic [DATA_W-1:0]          epc_wdata;
    logic [DATA_W-1:0]          epc_rdata;
    logic                       epc_rdy;
    logic [NUM_CH-1:0]          p_ncs;
    logic                       p_rs;
    logic                       p_nrd;
    logic                       p_nwr;
    logic [DATA_W-1:0]          p_wdata;
    logic [NUM_CH*DATA_W-1:0]   p_rdata;
    logic [NUM_CH-1:0]          p_rdy;
    logic                       err_clr;
    logic                       timeout_err;
    logic                       decode_err;

    modport slave (
        input  epc_ncs, epc_addr, epc_nrd, epc_nwr, epc_wdata, p_rdata, p_rdy, err_clr,
        output epc_rdata, epc_rdy, p_ncs, p_rs, p_nrd, p_nwr, p_wdata, timeout_err, decode_err
    );

    modport master (
        output epc_ncs, epc_addr, epc_nrd, epc_nwr, epc_wdata, p_rdata, p_rdy, err_clr,
        input  epc_rdata, epc_rdy, p_ncs, p_rs, p_nrd, p_nwr, p_wdata, timeout_err, decode_err
    );
endinterface

// File: rtl/epc_bridge.sv
// ----------------------------------------------------------------------------
// epc_bridge
// Bridges an asynchronous EPC master onto NUM_CH simple peripheral channels.
// An access is detected on the synchronised EPC strobes, the target channel
// is strobed with one cycle of address/data setup, and the bridge waits for
// the channel ready (bounded by TIMEOUT cycles) before signalling epc_rdy
// until the master releases its strobe.
// Ports:
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  epc_bridge_if.slave (EPC master side + peripheral channel side)
// ----------------------------------------------------------------------------
module epc_bridge #(
    parameter int unsigned       NUM_CH   = 4,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = '1
) (
    input  logic          clk,
    input  logic          rst,
    epc_bridge_if.slave   bus
);

    localparam int unsigned CH_W    = ADDR_W - 3;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

    state_e            r_state;
    state_e            w_state_nxt;

    // Two-stage synchronisers for the asynchronous EPC controls
    logic              r_ncs_meta, r_ncs_sync;
    logic              r_nrd_meta, r_nrd_sync;
    logic              r_nwr_meta, r_nwr_sync;

    // Set once IDLE has seen both strobes released; gates the next start
    logic              r_armed;

    logic [CH_W-1:0]   r_ch;
    logic              r_rs;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [15:0]       r_cnt;
    logic              r_timeout_err;
    logic              r_decode_err;

    logic [CH_W-1:0]   w_addr_ch;
    logic              w_ch_ok;
    logic              w_start;
    logic              w_dec_err;
    logic              w_own_rel;
    logic              w_abort;
    logic              w_rdy_sel;
    logic [DATA_W-1:0] w_rdata_sel;
    logic              w_capture;
    logic              w_set_to;
    logic              w_set_dec;
    logic [NUM_CH-1:0] w_p_ncs;
    logic              w_p_nrd;
    logic              w_p_nwr;

    assign w_addr_ch = bus.epc_addr[ADDR_W-1:3];

    // The EPC address is sampled directly at detection: the master holds it
    // stable for the whole strobe, which is already two cycles old by then.
    always_comb begin
        w_ch_ok = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (w_addr_ch == CH_W'(k)) begin
                w_ch_ok = 1'b1;
            end
        end
    end

    assign w_start   = (r_state == StIdle) && r_armed && !r_ncs_sync &&
                       (!r_nrd_sync || !r_nwr_sync);
    assign w_dec_err = !w_ch_ok || (bus.epc_addr[1:0] != 2'b00) || (!r_nrd_sync && !r_nwr_sync);

    // Released = the strobe of the latched direction is back high
    assign w_own_rel = r_wr ? r_nwr_sync : r_nrd_sync;
    assign w_abort   = w_own_rel || r_ncs_sync;

    always_comb begin
        w_rdy_sel   = 1'b0;
        w_rdata_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (r_ch == CH_W'(k)) begin
                w_rdy_sel   = bus.p_rdy[k];
                w_rdata_sel = bus.p_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_set_to    = 1'b0;
        w_set_dec   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    if (w_dec_err) begin
                        w_state_nxt = StHold;
                        w_set_dec   = 1'b1;
                    end else begin
                        w_state_nxt = StSetup;
                    end
                end
            end
            StSetup: begin
                w_state_nxt = w_abort ? StIdle : StAccess;
            end
            StAccess: begin
                if (w_abort) begin
                    w_state_nxt = StIdle;
                end else if (w_rdy_sel) begin
                    // Ready takes priority over a timeout in the same cycle
                    w_state_nxt = StHold;
                    w_capture   = !r_wr;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = StHold;
                    w_set_to    = 1'b1;
                end
            end
            StHold: begin
                if (w_own_rel) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Peripheral strobes decode straight from state so reset acts at once
    always_comb begin
        w_p_ncs = '1;
        w_p_nrd = 1'b1;
        w_p_nwr = 1'b1;
        if (r_state == StSetup || r_state == StAccess) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (r_ch == CH_W'(k)) begin
                    w_p_ncs[k] = 1'b0;
                end
            end
        end
        if (r_state == StAccess) begin
            w_p_nrd = r_wr;
            w_p_nwr = !r_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_ncs_meta    <= 1'b1;
            r_ncs_sync    <= 1'b1;
            r_nrd_meta    <= 1'b1;
            r_nrd_sync    <= 1'b1;
            r_nwr_meta    <= 1'b1;
            r_nwr_sync    <= 1'b1;
            r_armed       <= 1'b0;
            r_ch          <= '0;
            r_rs          <= 1'b0;
            r_wr          <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
            r_decode_err  <= 1'b0;
        end else begin
            r_ncs_meta <= bus.epc_ncs;
            r_ncs_sync <= r_ncs_meta;
            r_nrd_meta <= bus.epc_nrd;
            r_nrd_sync <= r_nrd_meta;
            r_nwr_meta <= bus.epc_nwr;
            r_nwr_sync <= r_nwr_meta;

            r_state <= w_state_nxt;

            if (r_state != StIdle || w_start) begin
                r_armed <= 1'b0;
            end else if (r_nrd_sync && r_nwr_sync) begin
                r_armed <= 1'b1;
            end

            if (w_start) begin
                r_ch    <= w_addr_ch;
                r_rs    <= bus.epc_addr[2];
                // Both strobes low is a decode error; it is then held as a write
                r_wr    <= !r_nwr_sync;
                r_wdata <= bus.epc_wdata;
            end

            if (r_state == StSetup) begin
                r_cnt <= '0;
            end else if (r_state == StAccess) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_set_dec || w_set_to) begin
                r_rdata <= ERR_DATA;
            end else if (w_capture) begin
                r_rdata <= w_rdata_sel;
            end

            if (w_set_to) begin
                r_timeout_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_timeout_err <= 1'b0;
            end

            if (w_set_dec) begin
                r_decode_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_decode_err <= 1'b0;
            end
        end
    end

    assign bus.p_ncs       = w_p_ncs;
    assign bus.p_nrd       = w_p_nrd;
    assign bus.p_nwr       = w_p_nwr;
    assign bus.p_rs        = r_rs;
    assign bus.p_wdata     = r_wdata;
    assign bus.epc_rdata   = r_rdata;
    assign bus.epc_rdy     = (r_state == StHold);
    assign bus.timeout_err = r_timeout_err;
    assign bus.decode_err  = r_decode_err;

endmodule

// File: tb/tb_epc_bridge.sv
// ----------------------------------------------------------------------------
// tb_epc_bridge
// Directed bench for epc_bridge (NUM_CH=4, DATA_W=8, ADDR_W=6, TIMEOUT=16).
// A vector table covers reads, writes, timeout and decode errors; short
// hand-written sequences cover abort, reset mid-access and both strobes low.
// ----------------------------------------------------------------------------
module tb_epc_bridge;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    epc_bridge_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    epc_bridge #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Peripheral stub: selected channel goes ready after rdy_delay strobe cycles
    // (rdy_delay == 0 means never ready).
    int unsigned rdy_delay  = 0;
    int unsigned periph_cnt = 0;
    logic        periph_active;

    assign periph_active = (bus.p_ncs != 4'hF) && (!bus.p_nrd || !bus.p_nwr);

    always @(posedge clk) begin
        periph_cnt <= periph_active ? periph_cnt + 1 : 0;
    end

    always_comb begin
        bus.p_rdy = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rdy_delay != 0 && periph_active && !bus.p_ncs[k] && periph_cnt + 1 >= rdy_delay) begin
                bus.p_rdy[k] = 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Observations collected over one transaction
    int unsigned obs_nwr;
    int unsigned obs_nrd;
    logic [3:0]  obs_ncs;
    logic        obs_rs;
    logic [7:0]  obs_wd;

    task automatic observe();
        obs_ncs = obs_ncs & bus.p_ncs;
        if (!bus.p_nwr) obs_nwr++;
        if (!bus.p_nrd) obs_nrd++;
        if (bus.p_ncs != 4'hF) begin
            obs_rs = bus.p_rs;
            obs_wd = bus.p_wdata;
        end
    endtask

    task automatic set_rdata(input logic [5:0] addr, input logic [7:0] slice);
        logic [2:0] ch;
        ch = addr[5:3];
        for (int k = 0; k < NUM_CH; k++) begin
            bus.p_rdata[k*8 +: 8] = (k == int'(ch)) ? slice : 8'(8'h10 + k);
        end
    endtask

    // Full master transaction; lat/drop are 0 if their cycle budget expires
    task automatic run_txn(input logic is_wr, input logic both, input logic [5:0] addr,
                           input logic [7:0] wdata, output int unsigned lat,
                           output int unsigned drop);
        lat = 0; drop = 0;
        obs_nwr = 0; obs_nrd = 0; obs_ncs = 4'hF; obs_rs = 1'b0; obs_wd = 8'h00;
        @(negedge clk);
        bus.epc_addr  = addr;
        bus.epc_wdata = wdata;
        bus.epc_ncs   = 1'b0;
        if (is_wr || both) bus.epc_nwr = 1'b0;
        if (!is_wr || both) bus.epc_nrd = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            observe();
            if (bus.epc_rdy) begin
                lat = k;
                break;
            end
        end
        bus.epc_nrd = 1'b1;
        bus.epc_nwr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            observe();
            if (!bus.epc_rdy) begin
                drop = k;
                break;
            end
        end
        bus.epc_ncs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    typedef struct {
        logic        is_wr;
        logic [5:0]  addr;
        logic [7:0]  wdata;
        int unsigned delay;
        logic [7:0]  slice;
        int unsigned exp_lat;
        int unsigned exp_cyc;
        logic [3:0]  exp_ncs;
        logic        exp_rs;
        logic [7:0]  exp_rdata;
        logic        exp_dec;
        logic        exp_to;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int unsigned lat;
        int unsigned drop;

        // wr  addr   wdata delay slice lat cyc ncs    rs rdata dec to
        vecs[0] = '{1'b1, 6'h08, 8'h41, 4, 8'h00, 8,  4,  4'b1101, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 6'h1C, 8'h00, 1, 8'hA5, 5,  1,  4'b0111, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 6'h00, 8'h00, 2, 8'h3C, 6,  2,  4'b1110, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 6'h14, 8'h9E, 1, 8'hC3, 5,  1,  4'b1011, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 6'h10, 8'h00, 0, 8'h66, 20, 16, 4'b1011, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 6'h0C, 8'h00, 3, 8'h77, 7,  3,  4'b1101, 1'b1, 8'h77, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 6'h20, 8'h00, 1, 8'h00, 3,  0,  4'b1111, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 6'h08, 8'h00, 1, 8'h12, 5,  1,  4'b1101, 1'b0, 8'h12, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 6'h01, 8'h33, 1, 8'h00, 3,  0,  4'b1111, 1'b0, 8'hFF, 1'b1, 1'b0};

        bus.epc_ncs   = 1'b1;
        bus.epc_nrd   = 1'b1;
        bus.epc_nwr   = 1'b1;
        bus.epc_addr  = '0;
        bus.epc_wdata = '0;
        bus.err_clr   = 1'b0;
        bus.p_rdata   = '0;

        repeat (2) @(negedge clk);
        check("reset p_ncs", 32'(bus.p_ncs), 32'hF);
        check("reset epc_rdy", 32'(bus.epc_rdy), 32'h0);
        check("reset epc_rdata", 32'(bus.epc_rdata), 32'h0);
        check("reset flags", 32'({bus.timeout_err, bus.decode_err}), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            rdy_delay = vecs[i].delay;
            set_rdata(vecs[i].addr, vecs[i].slice);
            run_txn(vecs[i].is_wr, 1'b0, vecs[i].addr, vecs[i].wdata, lat, drop);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d p_nwr cycles", i), obs_nwr,
                  vecs[i].is_wr ? vecs[i].exp_cyc : 0);
            check($sformatf("v%0d p_nrd cycles", i), obs_nrd,
                  vecs[i].is_wr ? 0 : vecs[i].exp_cyc);
            check($sformatf("v%0d p_ncs", i), 32'(obs_ncs), 32'(vecs[i].exp_ncs));
            if (vecs[i].exp_ncs != 4'hF) begin
                check($sformatf("v%0d p_rs", i), 32'(obs_rs), 32'(vecs[i].exp_rs));
            end
            if (vecs[i].is_wr && vecs[i].exp_ncs != 4'hF) begin
                check($sformatf("v%0d p_wdata", i), 32'(obs_wd), 32'(vecs[i].wdata));
            end
            check($sformatf("v%0d epc_rdata", i), 32'(bus.epc_rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("v%0d decode_err", i), 32'(bus.decode_err), 32'(vecs[i].exp_dec));
            check($sformatf("v%0d timeout_err", i), 32'(bus.timeout_err), 32'(vecs[i].exp_to));
            check($sformatf("v%0d rdy drop", i), drop, 3);
            if (vecs[i].exp_dec || vecs[i].exp_to) begin
                pulse_err_clr();
                check($sformatf("v%0d err_clr", i),
                      32'({bus.timeout_err, bus.decode_err}), 32'h0);
            end
        end

        // Abort: master releases nrd while the bridge sits in ACCESS
        begin
            logic rdy_seen;
            rdy_seen  = 1'b0;
            rdy_delay = 0;
            set_rdata(6'h08, 8'h44);
            @(negedge clk);
            bus.epc_addr = 6'h08;
            bus.epc_ncs  = 1'b0;
            bus.epc_nrd  = 1'b0;
            repeat (6) begin
                @(negedge clk);
                rdy_seen = rdy_seen | bus.epc_rdy;
            end
            check("abort in access", 32'({bus.p_nrd, bus.p_ncs}), 32'({1'b0, 4'b1101}));
            bus.epc_nrd = 1'b1;
            repeat (3) begin
                @(negedge clk);
                rdy_seen = rdy_seen | bus.epc_rdy;
            end
            check("abort idle", 32'({bus.p_nrd, bus.p_ncs}), 32'({1'b1, 4'hF}));
            bus.epc_ncs = 1'b1;
            repeat (8) begin
                @(negedge clk);
                rdy_seen = rdy_seen | bus.epc_rdy;
            end
            check("abort epc_rdy", 32'(rdy_seen), 32'h0);
            check("abort epc_rdata", 32'(bus.epc_rdata), 32'hFF);
            check("abort timeout_err", 32'(bus.timeout_err), 32'h0);
        end

        // Reset pulse mid-access must return every output to reset values at once
        rdy_delay = 0;
        @(negedge clk);
        bus.epc_addr  = 6'h14;
        bus.epc_wdata = 8'h5C;
        bus.epc_ncs   = 1'b0;
        bus.epc_nrd   = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset access", 32'({bus.p_nrd, bus.p_rs, bus.p_ncs, bus.p_wdata}),
              32'({1'b0, 1'b1, 4'b1011, 8'h5C}));
        rst = 1'b1;
        #1;
        check("rst p_ncs/strobes", 32'({bus.p_ncs, bus.p_nrd, bus.p_nwr, bus.p_rs}),
              32'({4'hF, 1'b1, 1'b1, 1'b0}));
        check("rst p_wdata", 32'(bus.p_wdata), 32'h0);
        check("rst epc_rdata", 32'(bus.epc_rdata), 32'h0);
        check("rst rdy/flags", 32'({bus.epc_rdy, bus.timeout_err, bus.decode_err}), 32'h0);
        @(negedge clk);
        bus.epc_nrd = 1'b1;
        bus.epc_ncs = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Both strobes low at the start is a decode error
        rdy_delay = 1;
        set_rdata(6'h08, 8'h21);
        run_txn(1'b0, 1'b1, 6'h08, 8'h00, lat, drop);
        check("both latency", lat, 3);
        check("both p_ncs", 32'(obs_ncs), 32'hF);
        check("both strobes", obs_nrd + obs_nwr, 0);
        check("both epc_rdata", 32'(bus.epc_rdata), 32'hFF);
        check("both flags", 32'({bus.timeout_err, bus.decode_err}), 32'h1);
        check("both rdy drop", drop, 3);
        pulse_err_clr();
        check("both err_clr", 32'(bus.decode_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/epc_bridge.md
EPC_BRIDGE -- requirements
Module: epc_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of peripheral channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 8, data bus width.
REQ-003 SHALL have parameter ADDR_W, default 6, EPC address width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles waiting for peripheral ready (1..65535).
REQ-005 SHALL have parameter ERR_DATA, default all-ones, read data returned on decode error or timeout.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 epc_ncs  input  1  EPC chip select, active low, asynchronous to clk.
REQ-009 epc_addr  input  ADDR_W  EPC address: [1:0] byte offset, [2] register select, [ADDR_W-1:3] channel index.
REQ-010 epc_nrd / epc_nwr  input  1 each  EPC read/write strobes, active low, asynchronous.
REQ-011 epc_wdata  input  DATA_W  write data from master.
REQ-012 epc_rdata  output  DATA_W  registered read data to master.
REQ-013 epc_rdy  output  1  access complete to master, active high.
REQ-014 p_ncs  output  NUM_CH  per-channel chip select, active low, one-cold.
REQ-015 p_rs / p_nrd / p_nwr  output  1 each  register select (=epc_addr[2]), read strobe, write strobe (strobes active low).
REQ-016 p_wdata  output  DATA_W  latched write data.
REQ-017 p_rdata  input  NUM_CH*DATA_W  read data, channel k at [k*DATA_W +: DATA_W].
REQ-018 p_rdy  input  NUM_CH  per-channel ready, active high.
REQ-019 err_clr  input  1  clears sticky error flags.
REQ-020 timeout_err / decode_err  output  1 each  sticky error flags.

Function
REQ-021 epc_ncs, epc_nrd, epc_nwr SHALL pass through 2-FF synchronisers; FSM uses only synchronised copies.
REQ-022 FSM states SHALL be IDLE, SETUP, ACCESS, HOLD.
REQ-023 IDLE: on synchronised ncs low and exactly one strobe low, latch address, rs, direction, epc_wdata; go SETUP next cycle.
REQ-024 Decode error (channel >= NUM_CH, epc_addr[1:0] != 0, or both strobes low at start) SHALL skip the peripheral, set decode_err, load epc_rdata=ERR_DATA, go directly to HOLD.
REQ-025 SETUP: one cycle, p_ncs[ch] low, strobes high (address/data setup); go ACCESS.
REQ-026 ACCESS: p_ncs[ch] low and p_nrd or p_nwr low; wait counter increments each cycle from 0.
REQ-027 ACCESS exit on p_rdy[ch]=1: on read, capture p_rdata channel slice into epc_rdata; go HOLD.
REQ-028 ACCESS exit when counter reaches TIMEOUT without ready: set timeout_err, epc_rdata=ERR_DATA, go HOLD; p_rdy and timeout in same cycle -> ready wins.
REQ-029 HOLD: epc_rdy=1, peripheral strobes high, p_ncs all high; remain until synchronised master strobe returns high, then go IDLE with epc_rdy=0.
REQ-030 Master strobe deasserting during SETUP/ACCESS (abort) SHALL return to IDLE next cycle, deassert all peripheral signals, never assert epc_rdy, leave epc_rdata unchanged.
REQ-031 Latency: epc_rdy SHALL assert 3 clk after IDLE detection when p_rdy is already high (5 clk after pin change); decode error 1 clk after detection.
REQ-032 A new access SHALL NOT start until the FSM has passed through IDLE with both synchronised strobes high.
REQ-033 err_clr SHALL clear both sticky flags; same-cycle set and clear -> set wins.
REQ-034 epc_rdata SHALL hold its value outside captures; writes SHALL NOT change it.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, p_ncs all ones, p_nrd=p_nwr=1, p_rs=0, p_wdata=0, epc_rdata=0, epc_rdy=0, flags=0, counter=0, synchronisers to 1, including mid-access.

Verification
REQ-036 Write ch1 reg0: addr 0x08, wdata 0x41, p_rdy[1] high after 4 cycles -> p_ncs=4'b1101, p_rs=0, p_wdata=0x41, p_nwr low 4 cycles, epc_rdy until master nwr high.
REQ-037 Read ch3 reg1: addr 0x1C, p_rdata slice 0xA5, p_rdy immediate -> epc_rdata=0xA5, epc_rdy 3 clk after detection, p_rs=1.
REQ-038 Timeout: p_rdy tied 0, TIMEOUT=16 -> ACCESS exactly 16 cycles, timeout_err=1, epc_rdata=0xFF; err_clr pulse -> 0.
REQ-039 Decode errors: addr 0x20 (ch4, NUM_CH=4) and addr 0x01 -> no p_ncs activity, decode_err=1, epc_rdata=0xFF.
REQ-040 Abort and reset: master nrd high during ACCESS -> IDLE, epc_rdy never high; rst pulse during ACCESS -> all outputs at reset values same cycle.
